// File: rtl/video_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen_if
// Description : Bundle between the video timing generator, the pixel source
//               and the downstream video interface. The master side (timing
//               generator) issues active-area pixel requests, receives the
//               pixel one clock later and drives the aligned video outputs.
//
//               req_valid   : pixel request for req_x/req_y this cycle
//               req_x/req_y : active-area column/row being requested
//               pix_rgb     : pixel returned one clock after the request
//               vid_rgb     : output pixel, 0 whenever vid_de is low
//               vid_de      : data enable
//               vid_hs/vs   : horizontal/vertical sync, active high
//               frame_start : pulse on the first active pixel of a frame
//               frame_cnt   : completed-frame counter, wraps 255->0
// Revision    : 1.0 - initial release
// ============================================================================
interface video_timing_gen_if;
    logic        req_valid;
    logic [9:0]  req_x;
    logic [9:0]  req_y;
    logic [23:0] pix_rgb;
    logic [23:0] vid_rgb;
    logic        vid_de;
    logic        vid_hs;
    logic        vid_vs;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    // Timing generator side
    modport master (
        output req_valid,
        output req_x,
        output req_y,
        input  pix_rgb,
        output vid_rgb,
        output vid_de,
        output vid_hs,
        output vid_vs,
        output frame_start,
        output frame_cnt
    );

    // Pixel source / video sink side
    modport slave (
        input  req_valid,
        input  req_x,
        input  req_y,
        output pix_rgb,
        input  vid_rgb,
        input  vid_de,
        input  vid_hs,
        input  vid_vs,
        input  frame_start,
        input  frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Pixel-clock video timing generator with a 3-stage pipeline:
//               stage 0 counters + pixel request, stage 1 flags while the
//               pixel source fetches, stage 2 registered video outputs.
//               The generator runs only while the synchronised PLL lock is
//               high; losing lock parks the counters at 0 and drains the
//               pipeline with zeros, relock restarts a full frame.
//
//   clk        : pixel clock
//   rst        : synchronous active-high reset
//   pll_locked : PLL lock, asynchronous to clk
//   bus        : request / pixel / video bundle (master modport)
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              pll_locked,
    video_timing_gen_if.master     bus
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] c_HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // ------------------------------------------------------------------
    // Lock synchroniser: pll_locked comes from the PLL, not from clk.
    // ------------------------------------------------------------------
    logic meta_q;
    logic run_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            meta_q <= pll_locked;
            run_q  <= meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: raster counters. Without lock they are parked at 0 so that
    // the first cycle with run=1 is already pixel (0,0) of a new frame.
    // ------------------------------------------------------------------
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!run_q) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == c_H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == c_V_LAST) ? '0 : v_cnt_q + 10'd1;
        end else begin
            h_cnt_d = h_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Stage 0 decode; every flag is qualified by run so a lost lock turns
    // the whole pipeline into zeros.
    logic w_de0;
    logic w_hs0;
    logic w_vs0;
    logic w_first0;

    always_comb begin
        w_de0    = run_q && (h_cnt_q < c_H_ACT) && (v_cnt_q < c_V_ACT);
        w_hs0    = run_q && (h_cnt_q >= c_HS_BEGIN) && (h_cnt_q < c_HS_END);
        // Vertical sync depends on v_cnt only, so it spans whole lines and
        // changes together with the h_cnt wrap.
        w_vs0    = run_q && (v_cnt_q >= c_VS_BEGIN) && (v_cnt_q < c_VS_END);
        w_first0 = run_q && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    assign bus.req_valid = w_de0;
    assign bus.req_x     = h_cnt_q;
    assign bus.req_y     = v_cnt_q;

    // ------------------------------------------------------------------
    // Stage 1: flags wait here while the pixel source answers the request.
    // ------------------------------------------------------------------
    logic de1_q;
    logic hs1_q;
    logic vs1_q;
    logic first1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            de1_q    <= 1'b0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            first1_q <= 1'b0;
        end else begin
            de1_q    <= w_de0;
            hs1_q    <= w_hs0;
            vs1_q    <= w_vs0;
            first1_q <= w_first0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: registered video outputs and the frame counter.
    // ------------------------------------------------------------------
    logic [23:0] vid_rgb_q, vid_rgb_d;
    logic        vid_de_q;
    logic        vid_hs_q;
    logic        vid_vs_q;
    logic        frame_start_q;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    // Set once a frame start has been seen since run rose; the start that
    // follows (re)lock opens a frame rather than completing one.
    logic        armed_q, armed_d;

    always_comb begin
        vid_rgb_d   = de1_q ? bus.pix_rgb : '0;
        frame_cnt_d = frame_cnt_q;
        armed_d     = run_q && (armed_q || first1_q);
        // frame_cnt moves on the same edge that raises frame_start, so the
        // new count is visible during the frame_start cycle.
        if (first1_q && armed_q) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vid_rgb_q     <= '0;
            vid_de_q      <= 1'b0;
            vid_hs_q      <= 1'b0;
            vid_vs_q      <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            armed_q       <= 1'b0;
        end else begin
            vid_rgb_q     <= vid_rgb_d;
            vid_de_q      <= de1_q;
            vid_hs_q      <= hs1_q;
            vid_vs_q      <= vs1_q;
            frame_start_q <= first1_q;
            frame_cnt_q   <= frame_cnt_d;
            armed_q       <= armed_d;
        end
    end

    assign bus.vid_rgb     = vid_rgb_q;
    assign bus.vid_de      = vid_de_q;
    assign bus.vid_hs      = vid_hs_q;
    assign bus.vid_vs      = vid_vs_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Directed bench for video_timing_gen on a reduced raster:
//               active 16x8, H total 30 (fp 4, sync 6, bp 4),
//               V total 15 (fp 2, sync 2, bp 3), 450 clocks per frame.
//               A pixel source model returns {y[7:0], x[7:0], 8'hA5} one
//               clock after each request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    logic clk;
    logic rst;
    logic pll_locked;

    int checks = 0;
    int errors = 0;

    video_timing_gen_if bus_if ();

    video_timing_gen #(
        .H_ACTIVE (16),
        .H_FP     (4),
        .H_SYNC   (6),
        .H_BP     (4),
        .V_ACTIVE (8),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .bus        (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pixel source: fixed one-clock latency
    always @(posedge clk) begin
        bus_if.pix_rgb <= {bus_if.req_y[7:0], bus_if.req_x[7:0], 8'hA5};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // All request/video outputs low, packed into one word
    function automatic logic [31:0] quiet_word();
        return 32'({bus_if.req_valid, bus_if.vid_de, bus_if.vid_hs,
                    bus_if.vid_vs, bus_if.frame_start, bus_if.vid_rgb});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_line0 = 0, de_line0 = 0, hs_line0 = 0, vs_cnt = 0;
        int de_first = -1, de_rise2 = -1, de_fall = -1, hs_rise = -1, vs_rise = -1;
        int fs_cnt = 0, fs1 = -1, fs2 = -1, rgb_bad = 0, wait_cnt;
        logic prev_de = 1'b0, prev_hs = 1'b0, prev_vs = 1'b0;
        logic [7:0]  fc451 = '0, fc452 = '0;
        logic [23:0] rgb97 = '0;
        logic [19:0] xy95 = '0;

        // ---------------- reset / lock ----------------
        rst        = 1'b1;
        pll_locked = 1'b0;
        step(4);
        chk("rst_quiet", quiet_word(), 32'd0);
        chk("rst_frame_cnt", 32'(bus_if.frame_cnt), 32'd0);
        rst = 1'b0;
        step(3);
        chk("unlocked_no_req", 32'(bus_if.req_valid), 32'd0);
        pll_locked = 1'b1;
        step(1);
        chk("lock_sync_1clk", 32'(bus_if.req_valid), 32'd0);
        step(1);
        chk("lock_req_valid", 32'(bus_if.req_valid), 32'd1);
        chk("lock_req_xy", 32'({bus_if.req_x, bus_if.req_y}), 32'd0);

        // ---------------- one frame + 10 pixels, k=0 is pixel (0,0) ----------------
        for (int k = 0; k <= 460; k++) begin
            if (k > 0) step(1);
            if (k < 30) begin
                rv_line0 += int'(bus_if.req_valid);
                de_line0 += int'(bus_if.vid_de);
                hs_line0 += int'(bus_if.vid_hs);
            end
            if (bus_if.vid_de && !prev_de) begin
                if (de_first < 0) de_first = k;
                else if (de_rise2 < 0) de_rise2 = k;
            end
            if (!bus_if.vid_de && prev_de && de_fall < 0) de_fall = k;
            if (bus_if.vid_hs && !prev_hs && hs_rise < 0) hs_rise = k;
            if (bus_if.vid_vs && !prev_vs && vs_rise < 0) vs_rise = k;
            vs_cnt += int'(bus_if.vid_vs);
            if (bus_if.frame_start) begin
                fs_cnt++;
                if (fs1 < 0) fs1 = k;
                else if (fs2 < 0) fs2 = k;
            end
            if (!bus_if.vid_de && bus_if.vid_rgb != '0) rgb_bad++;
            if (k == 95)  xy95  = {bus_if.req_x, bus_if.req_y};
            if (k == 97)  rgb97 = bus_if.vid_rgb;
            if (k == 451) fc451 = bus_if.frame_cnt;
            if (k == 452) fc452 = bus_if.frame_cnt;
            prev_de = bus_if.vid_de;
            prev_hs = bus_if.vid_hs;
            prev_vs = bus_if.vid_vs;
        end

        chk("line_req_count", 32'(rv_line0), 32'd16);
        chk("line_de_count", 32'(de_line0), 32'd16);
        chk("de_first_k", 32'(de_first), 32'd2);
        chk("de_fall_k", 32'(de_fall), 32'd18);
        chk("hs_rise_k", 32'(hs_rise), 32'd22);
        chk("hs_width", 32'(hs_line0), 32'd6);
        chk("line_period", 32'(de_rise2 - de_first), 32'd30);
        chk("fs_first_k", 32'(fs1), 32'd2);
        chk("frame_period", 32'(fs2 - fs1), 32'd450);
        chk("fs_count", 32'(fs_cnt), 32'd2);
        chk("vs_rise_k", 32'(vs_rise), 32'd302);
        chk("vs_length", 32'(vs_cnt), 32'd60);
        chk("fcnt_before_2nd_fs", 32'(fc451), 32'd0);
        chk("fcnt_at_2nd_fs", 32'(fc452), 32'd1);
        chk("req_xy_5_3", 32'(xy95), 32'({10'd5, 10'd3}));
        chk("rgb_5_3", 32'(rgb97), 32'h0305A5);
        chk("rgb_zero_no_de", 32'(rgb_bad), 32'd0);

        // ---------------- lock drop at line 5, pixel 10 (k=610) ----------------
        step(150);
        chk("drop_point_xy", 32'({bus_if.req_x, bus_if.req_y}), 32'({10'd10, 10'd5}));
        pll_locked = 1'b0;
        step(2);
        chk("drop_req_gated", 32'(bus_if.req_valid), 32'd0);
        step(1);
        chk("drop_counters_zero", 32'({bus_if.req_x, bus_if.req_y}), 32'd0);
        step(1);
        chk("drop_quiet_4clk", quiet_word(), 32'd0);
        chk("drop_fcnt_hold", 32'(bus_if.frame_cnt), 32'd1);
        step(20);
        chk("drop_quiet_later", quiet_word(), 32'd0);
        chk("drop_fcnt_hold_later", 32'(bus_if.frame_cnt), 32'd1);

        // ---------------- relock ----------------
        pll_locked = 1'b1;
        step(1);
        chk("relock_sync_1clk", 32'(bus_if.req_valid), 32'd0);
        step(1);
        chk("relock_req_valid", 32'(bus_if.req_valid), 32'd1);
        chk("relock_req_xy", 32'({bus_if.req_x, bus_if.req_y}), 32'd0);
        step(2);
        chk("relock_frame_start", 32'(bus_if.frame_start), 32'd1);
        chk("relock_fcnt_same", 32'(bus_if.frame_cnt), 32'd1);
        wait_cnt = 0;
        do begin
            step(1);
            wait_cnt++;
        end while (!bus_if.frame_start && wait_cnt < 500);
        chk("relock_frame_period", 32'(wait_cnt), 32'd450);
        chk("relock_fcnt_incr", 32'(bus_if.frame_cnt), 32'd2);

        // ---------------- reset at line 7, pixel 15 ----------------
        step(223);
        chk("rst_point_xy", 32'({bus_if.req_x, bus_if.req_y}), 32'({10'd15, 10'd7}));
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_quiet", quiet_word(), 32'd0);
        chk("midrst_counters", 32'({bus_if.req_x, bus_if.req_y}), 32'd0);
        chk("midrst_fcnt", 32'(bus_if.frame_cnt), 32'd0);
        step(1);
        chk("midrst_sync_1clk", 32'(bus_if.req_valid), 32'd0);
        step(1);
        chk("midrst_restart_req", 32'(bus_if.req_valid), 32'd1);
        chk("midrst_restart_xy", 32'({bus_if.req_x, bus_if.req_y}), 32'd0);
        step(2);
        chk("midrst_frame_start", 32'(bus_if.frame_start), 32'd1);
        chk("midrst_fcnt_first", 32'(bus_if.frame_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Pixel-clock-domain video timing generator. Runs on the 25 MHz pixel clock produced by the core PLL and gates itself on the PLL lock indication.
- Produces the active-area pixel request stream (x/y) to the pixel source and the aligned video output bundle (rgb/de/hs/vs) toward the Pocket video interface.
- Default geometry is 640x480, 800x525 total (~59.5 Hz at 25 MHz).

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hs pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vs pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  pixel clock (PLL outclk_0, 25 MHz)
- rst  in  1  synchronous, active-high reset
- pll_locked  in  1  PLL lock, asynchronous to clk
- req_valid  out  1  pixel request for the current req_x/req_y
- req_x  out  10  active-area column, 0..H_ACTIVE-1
- req_y  out  10  active-area row, 0..V_ACTIVE-1
- pix_rgb  in  24  pixel data returned with fixed 1-cycle latency after the request
- vid_rgb  out  24  output pixel; forced 0 when vid_de=0
- vid_de  out  1  data enable
- vid_hs  out  1  horizontal sync, active high
- vid_vs  out  1  vertical sync, active high
- frame_start  out  1  one-cycle pulse on the first active pixel of a frame, aligned to vid_*
- frame_cnt  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Timing totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
  - Region order per axis: active, front porch, sync, back porch.
- Lock synchronizer:
  - pll_locked passes through a 2-flop synchronizer; the result is `run`.
  - rst clears both flops.
- Counters:
  - h_cnt runs 0..H_TOTAL-1; v_cnt runs 0..V_TOTAL-1.
  - h_cnt increments every clk while run=1.
  - On h_cnt=H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 after V_TOTAL-1, in the same cycle h_cnt wraps.
- Stage 0 (cycle N):
  - req_valid = run & (h_cnt<H_ACTIVE) & (v_cnt<V_ACTIVE).
  - req_x = h_cnt[9:0], req_y = v_cnt[9:0]. Both are driven from registers; values outside the active area are don't-care.
- Stage 1 (cycle N+1):
  - Captures de/hs/vs/first flags from stage 0.
  - The pixel source drives pix_rgb during this cycle.
- Stage 2 (cycle N+2): registered outputs.
  - vid_de = de1
  - vid_rgb = de1 ? pix_rgb : 0
  - vid_hs = hs1, vid_vs = vs1
  - frame_start = first1
- Total latency from counter state to vid_* is 2 clocks.
- Sync decode:
  - hs = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, asserted for full lines, changing at h_cnt=0
  - first = (h_cnt==0 && v_cnt==0 && run)
- frame_cnt increments by 1 in the cycle frame_start is asserted, except the first frame after run rises, which does not increment.
- Reset (rst=1):
  - All counters, pipeline registers and outputs go to 0, including frame_cnt.
  - Takes effect at the next clk edge, including mid-frame.
  - After rst falls, counting resumes from h=0,v=0 once run=1.
- Loss of lock (run=0):
  - In the cycle after run falls, h_cnt/v_cnt are 0 and held there.
  - Stage flags are gated by run, so req_valid and all stage-0 flags are 0.
  - The pipeline drains 0s; vid_* are all 0 within 2 clocks.
  - frame_cnt holds its value.
- Relock (run rises): the first req_valid occurs in the same cycle as run=1 (h=0,v=0), which is a full-frame restart.
- Widths: counters are 10 bits. Parameter sums above 1024 are illegal (not checked).

Test Plan:
- Reset/lock: rst=1 for 4 clks, pll_locked=0 -> all outputs 0, req_valid=0. Set pll_locked=1 -> req_valid=1 with req_x=0, req_y=0 on the 2nd clk after the sync flops settle.
- Line timing: run one line -> 640 consecutive req_valid.
  - vid_de high for 640 clocks starting 2 clocks after the first req_valid.
  - vid_hs high for exactly 96 clocks, starting 16 clocks after vid_de falls.
  - Line period 800 clocks.
- Frame timing: run 2 frames -> frame_start pulses 420000 clocks apart.
  - vid_vs high for 1600 clocks, starting at line 490.
  - frame_cnt goes 0->1 at the second frame_start.
- Pixel alignment: pixel source returns {req_y[7:0], req_x[7:0], 8'hA5} one cycle later -> vid_rgb at x=5,y=3 equals 24'h0305A5. vid_rgb=0 whenever vid_de=0.
- Lock drop mid-frame: deassert pll_locked at line 100, pixel 300 -> within 4 clocks all vid_* are 0 and req_valid=0. Reassert -> frame restarts at x=0,y=0 with frame_start, and frame_cnt is unchanged across the gap.
- Mid-frame reset: assert rst for 1 clock at line 479, pixel 639 -> the next cycle shows counters 0, frame_cnt=0 and outputs 0. Counting restarts cleanly.
